// File: rtl/adc_ad79x8_seq_if.sv
// Pin and host-side bundle for the AD7908/AD7918/AD7928 sequencer.
//  slave  : the sequencer side (drives the ADC pins and the result bus)
//  master : the host/board side (drives controls and the ADC DOUT line)
// Signals:
//  spi_ss, spi_sck, spi_mosi  sequencer -> ADC (CS active-low, SCLK idles high)
//  spi_miso                   ADC DOUT -> sequencer
//  i_ch_mask, i_cont, i_sn_adc  host controls
//  o_busy, o_en_adc, o_adc_value, o_ch_valid, o_err  results and status
interface adc_ad79x8_seq_if #(
  parameter int RES_BITS = 12
);
  logic                    spi_ss;
  logic                    spi_sck;
  logic                    spi_mosi;
  logic                    spi_miso;
  logic [7:0]              i_ch_mask;
  logic                    i_cont;
  logic                    i_sn_adc;
  logic                    o_busy;
  logic                    o_en_adc;
  logic [8*RES_BITS-1:0]   o_adc_value;
  logic [7:0]              o_ch_valid;
  logic                    o_err;

  modport slave (
    output spi_ss, spi_sck, spi_mosi,
    input  spi_miso,
    input  i_ch_mask, i_cont, i_sn_adc,
    output o_busy, o_en_adc, o_adc_value, o_ch_valid, o_err
  );

  modport master (
    input  spi_ss, spi_sck, spi_mosi,
    output spi_miso,
    output i_ch_mask, i_cont, i_sn_adc,
    input  o_busy, o_en_adc, o_adc_value, o_ch_valid, o_err
  );
endinterface

// File: rtl/adc_ad79x8_seq.sv
// SPI sequencer for AD7908/AD7918/AD7928. Walks the enabled channels of a
// latched mask, writes the control word for each frame and stores the result
// that comes back one frame later, after checking its leading zero and
// channel address.
// Ports:
//  clk  system clock
//  rst  synchronous reset, active-high
//  bus  adc_ad79x8_seq_if.slave: ADC pins, host controls, result bus
// Parameters:
//  RES_BITS  12/10/8 result width, taken from DOUT[11 -: RES_BITS]
//  SCK_DIV   clk cycles per SCK half-period (>=1)
//  CS_IDLE   clk cycles CS is held high between frames (>=2)
//  RANGE, CODING  control-word bits
module adc_ad79x8_seq #(
  parameter int   RES_BITS = 12,
  parameter int   SCK_DIV  = 1,
  parameter int   CS_IDLE  = 2,
  parameter logic RANGE    = 1'b1,
  parameter logic CODING   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  adc_ad79x8_seq_if.slave bus
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int GAP_W = (CS_IDLE > 2) ? $clog2(CS_IDLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;     // clk count inside one SCK half-period
  logic [5:0]            hp_q, hp_d;       // 0: CS fall edge, 1..32: SCK edges, 33: CS rise
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [GAP_W-1:0]      hold_q, hold_d;   // post-sequence holdoff before a new trigger
  logic [7:0]            mask_q, mask_d;
  logic [7:0]            rem_q, rem_d;     // channels not yet addressed this sequence
  logic [2:0]            addr_q, addr_d;   // channel written in the current frame
  logic [2:0]            prev_q, prev_d;   // channel whose data arrives in this frame
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic [14:0]           tx_q, tx_d;
  logic [15:0]           rx_q, rx_d;
  logic                  ss_q, ss_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic                  err_q, err_d;
  logic [8*RES_BITS-1:0] val_q, val_d;
  logic [7:0]            vld_q, vld_d;

  logic [2:0]  cur_ch;
  logic [15:0] word;
  logic        tick;

  function automatic logic [2:0] lsb8(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hp_d    = hp_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    prev_d  = prev_q;
    first_d = first_q;
    last_d  = last_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    val_d   = val_q;
    vld_d   = vld_q;

    // Once every enabled channel has been addressed, the closing frame
    // re-addresses the lowest one so the last data word can be collected.
    cur_ch = (rem_q != 8'd0) ? lsb8(rem_q) : lsb8(mask_q);
    word   = {1'b1, 2'b00, cur_ch, 2'b11, 2'b00, RANGE, CODING, 4'hF};
    tick   = (div_q == DIV_W'(SCK_DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if ((bus.i_cont || bus.i_sn_adc) && (bus.i_ch_mask != 8'd0)) begin
          mask_d  = bus.i_ch_mask;
          rem_d   = bus.i_ch_mask;
          busy_d  = 1'b1;
          vld_d   = 8'd0;
          first_d = 1'b1;
          hp_d    = 6'd0;
          div_d   = '0;
          state_d = S_FRAME;
        end
      end

      S_FRAME: begin
        if (hp_q == 6'd0) begin
          ss_d   = 1'b0;
          mosi_d = word[15];
          tx_d   = word[14:0];
          addr_d = cur_ch;
          last_d = (rem_q == 8'd0);
          rem_d  = rem_q & ~(8'd1 << cur_ch);
          hp_d   = 6'd1;
          div_d  = '0;
        end else if (!tick) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          hp_d  = hp_q + 6'd1;
          if (hp_q == 6'd33) begin
            ss_d  = 1'b1;
            hp_d  = 6'd0;
            gap_d = '0;
            // Frame 0 returns stale data from before this sequence.
            if (!first_q) begin
              if (!rx_q[15] && (rx_q[14:12] == prev_q)) begin
                val_d[int'(prev_q)*RES_BITS +: RES_BITS] = rx_q[11 -: RES_BITS];
                vld_d[prev_q] = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            prev_d  = addr_q;
            first_d = 1'b0;
            state_d = last_q ? S_DONE : S_GAP;
          end else if (hp_q[0]) begin
            // SCK fall: ADC takes the current DIN bit, present the next one.
            sck_d  = 1'b0;
            mosi_d = tx_q[14];
            tx_d   = {tx_q[13:0], 1'b1};
          end else begin
            sck_d = 1'b1;
            rx_d  = {rx_q[14:0], bus.spi_miso};
          end
        end
      end

      S_GAP: begin
        // Leave one cycle for the FRAME entry edge so CS stays high CS_IDLE cycles.
        if (gap_q == GAP_W'(CS_IDLE - 2)) begin
          state_d = S_FRAME;
          hp_d    = 6'd0;
          div_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_DONE: begin
        en_d    = 1'b1;
        busy_d  = 1'b0;
        hold_d  = GAP_W'(CS_IDLE - 2);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      hp_q    <= 6'd0;
      gap_q   <= '0;
      hold_q  <= '0;
      mask_q  <= 8'd0;
      rem_q   <= 8'd0;
      addr_q  <= 3'd0;
      prev_q  <= 3'd0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      tx_q    <= '1;
      rx_q    <= 16'd0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b1;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      val_q   <= '0;
      vld_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      prev_q  <= prev_d;
      first_q <= first_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      err_q   <= err_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.spi_ss      = ss_q;
  assign bus.spi_sck     = sck_q;
  assign bus.spi_mosi    = mosi_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_en_adc    = en_q;
  assign bus.o_err       = err_q;
  assign bus.o_adc_value = val_q;
  assign bus.o_ch_valid  = vld_q;

endmodule

// File: tb/tb_adc_ad79x8_seq.sv
// Directed bench: two sequencers (12-bit/SCK_DIV=1/CS_IDLE=2 and
// 8-bit/SCK_DIV=3/CS_IDLE=3), each talking to a behavioural ADC that answers
// with the data of the channel addressed in the previous frame.
module tb_adc_ad79x8_seq;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   trig_cyc = 0;

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  adc_ad79x8_seq_if #(.RES_BITS(12)) ifa ();
  adc_ad79x8_seq_if #(.RES_BITS(8))  ifb ();

  adc_ad79x8_seq #(.RES_BITS(12), .SCK_DIV(1), .CS_IDLE(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave));
  adc_ad79x8_seq #(.RES_BITS(8), .SCK_DIV(3), .CS_IDLE(3)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.slave));

  // ADC models: sampled on the falling clk edge, away from DUT updates.
  logic [11:0] tbl_a [8];
  logic [11:0] tbl_b [8];
  logic [2:0]  addr_log_a [$];
  logic [2:0]  addr_log_b [$];
  int corrupt_a = -1;
  int nfall_a = 0, en_cnt_a = 0, err_cnt_a = 0, lowlen_a = 0, hilen_a = 0, gap_a = 0, en_cyc_a = 0, bad_a = 0;
  int nfall_b = 0, en_cnt_b = 0, err_cnt_b = 0, lowlen_b = 0, hilen_b = 0, per_b = 0, bad_b = 0;

  initial begin
    logic ss_l = 1'b1, sck_l = 1'b1;
    logic [16:0] din = '0;
    logic [15:0] dout = '0;
    logic [2:0]  prev = 3'd0;
    int fcnt = 0, rcnt = 0, low = 0, hi = 0;
    forever begin
      @(negedge clk);
      if (ss_l && !ifa.spi_ss) begin
        nfall_a++; gap_a = cyc - en_cyc_a; hilen_a = hi;
        dout = {1'b0, (int'(prev) == corrupt_a) ? (prev ^ 3'd1) : prev, tbl_a[prev]};
        fcnt = 0; rcnt = 0; low = 0; din = {16'd0, ifa.spi_mosi};
      end else if (!ss_l && ifa.spi_ss) begin
        lowlen_a = low; hi = 0;
        if (rcnt == 16) begin
          addr_log_a.push_back(din[13:11]);
          if (din[16:1] !== {1'b1, 2'b00, din[13:11], 2'b11, 2'b00, 2'b11, 4'hF}) bad_a++;
          prev = din[13:11];
        end
      end else if (!ifa.spi_ss) begin
        if (sck_l && !ifa.spi_sck && fcnt < 16) begin fcnt++; ifa.spi_miso = dout[16-fcnt]; end
        if (!sck_l && ifa.spi_sck) begin rcnt++; din = {din[15:0], ifa.spi_mosi}; end
      end
      if (!ifa.spi_ss) low++; else hi++;
      if (ifa.o_en_adc) begin en_cnt_a++; en_cyc_a = cyc; end
      if (ifa.o_err) err_cnt_a++;
      ss_l = ifa.spi_ss; sck_l = ifa.spi_sck;
    end
  end

  initial begin
    logic ss_l = 1'b1, sck_l = 1'b1;
    logic [16:0] din = '0;
    logic [15:0] dout = '0;
    logic [2:0]  prev = 3'd0;
    int fcnt = 0, rcnt = 0, low = 0, hi = 0, lastrise = 0;
    forever begin
      @(negedge clk);
      if (ss_l && !ifb.spi_ss) begin
        nfall_b++; hilen_b = hi;
        dout = {1'b0, prev, tbl_b[prev]};
        fcnt = 0; rcnt = 0; low = 0; din = {16'd0, ifb.spi_mosi};
      end else if (!ss_l && ifb.spi_ss) begin
        lowlen_b = low; hi = 0;
        if (rcnt == 16) begin
          addr_log_b.push_back(din[13:11]);
          if (din[16:1] !== {1'b1, 2'b00, din[13:11], 2'b11, 2'b00, 2'b11, 4'hF}) bad_b++;
          prev = din[13:11];
        end
      end else if (!ifb.spi_ss) begin
        if (sck_l && !ifb.spi_sck && fcnt < 16) begin fcnt++; ifb.spi_miso = dout[16-fcnt]; end
        if (!sck_l && ifb.spi_sck) begin
          rcnt++; din = {din[15:0], ifb.spi_mosi};
          per_b = cyc - lastrise; lastrise = cyc;
        end
      end
      if (!ifb.spi_ss) low++; else hi++;
      if (ifb.o_en_adc) en_cnt_b++;
      if (ifb.o_err) err_cnt_b++;
      ss_l = ifb.spi_ss; sck_l = ifb.spi_sck;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic trig_a(input logic [7:0] m);
    @(negedge clk); ifa.i_ch_mask = m; ifa.i_sn_adc = 1'b1; trig_cyc = cyc + 1;
    @(negedge clk); ifa.i_sn_adc = 1'b0;
  endtask

  task automatic trig_b(input logic [7:0] m);
    @(negedge clk); ifb.i_ch_mask = m; ifb.i_sn_adc = 1'b1;
    @(negedge clk); ifb.i_sn_adc = 1'b0;
  endtask

  task automatic wait_en_a(input int target, input int budget);
    int n = 0;
    while (en_cnt_a < target && n < budget) begin @(negedge clk); n++; end
    chk("en_a_timeout", 128'(en_cnt_a >= target), 128'(1));
  endtask

  task automatic wait_en_b(input int target, input int budget);
    int n = 0;
    while (en_cnt_b < target && n < budget) begin @(negedge clk); n++; end
    chk("en_b_timeout", 128'(en_cnt_b >= target), 128'(1));
  endtask

  initial begin
    int e0, f0;
    logic [95:0] ea;
    logic [63:0] eb;
    logic [11:0] t;
    ifa.i_ch_mask = 8'd0; ifa.i_cont = 1'b0; ifa.i_sn_adc = 1'b0; ifa.spi_miso = 1'b0;
    ifb.i_ch_mask = 8'd0; ifb.i_cont = 1'b0; ifb.i_sn_adc = 1'b0; ifb.spi_miso = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tbl_a[k] = 12'h000;
      tbl_b[k] = 12'(k * 12'h2D3 + 12'h15C);
    end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ss",    128'(ifa.spi_ss), 128'(1));
    chk("rst_sck",   128'(ifa.spi_sck), 128'(1));
    chk("rst_mosi",  128'(ifa.spi_mosi), 128'(1));
    chk("rst_busy",  128'(ifa.o_busy), 128'(0));
    chk("rst_en",    128'(ifa.o_en_adc), 128'(0));
    chk("rst_err",   128'(ifa.o_err), 128'(0));
    chk("rst_val",   128'(ifa.o_adc_value), 128'(0));
    chk("rst_vld",   128'(ifa.o_ch_valid), 128'(0));
    chk("rst_b_ss",  128'(ifb.spi_ss), 128'(1));
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // 1: one-shot, mask 05
    tbl_a[0] = 12'hA5A; tbl_a[2] = 12'h123; tbl_a[1] = 12'hFFF;
    addr_log_a.delete(); e0 = en_cnt_a; f0 = nfall_a;
    trig_a(8'h05);
    chk("t1_busy", 128'(ifa.o_busy), 128'(1));
    chk("t1_ss_pre", 128'(ifa.spi_ss), 128'(1));
    @(negedge clk);
    chk("t1_ss_fall", 128'(ifa.spi_ss), 128'(0));
    chk("t1_mosi15", 128'(ifa.spi_mosi), 128'(1));
    wait_en_a(e0 + 1, 300);
    repeat (20) @(negedge clk);
    chk("t1_len", 128'(en_cyc_a - trig_cyc), 128'(105));
    chk("t1_frames", 128'(nfall_a - f0), 128'(3));
    chk("t1_nlog", 128'(addr_log_a.size()), 128'(3));
    if (addr_log_a.size() == 3) begin
      chk("t1_add0", 128'(addr_log_a[0]), 128'(0));
      chk("t1_add1", 128'(addr_log_a[1]), 128'(2));
      chk("t1_add2", 128'(addr_log_a[2]), 128'(0));
    end
    chk("t1_lane0", 128'(ifa.o_adc_value[0 +: 12]), 128'(12'hA5A));
    chk("t1_lane2", 128'(ifa.o_adc_value[24 +: 12]), 128'(12'h123));
    chk("t1_lane1", 128'(ifa.o_adc_value[12 +: 12]), 128'(0));
    chk("t1_vld", 128'(ifa.o_ch_valid), 128'(8'h05));
    chk("t1_err", 128'(err_cnt_a), 128'(0));
    chk("t1_en1", 128'(en_cnt_a - e0), 128'(1));
    chk("t1_busy_end", 128'(ifa.o_busy), 128'(0));
    chk("t1_cslow", 128'(lowlen_a), 128'(33));
    chk("t1_cshigh", 128'(hilen_a), 128'(2));
    chk("t1_word", 128'(bad_a), 128'(0));

    // 3: returned address of ch2 corrupted
    tbl_a[0] = 12'h0F0; tbl_a[2] = 12'h777; corrupt_a = 2;
    e0 = en_cnt_a;
    trig_a(8'h05);
    wait_en_a(e0 + 1, 300);
    repeat (5) @(negedge clk);
    corrupt_a = -1;
    chk("t3_err", 128'(err_cnt_a), 128'(1));
    chk("t3_lane2", 128'(ifa.o_adc_value[24 +: 12]), 128'(12'h123));
    chk("t3_lane0", 128'(ifa.o_adc_value[0 +: 12]), 128'(12'h0F0));
    chk("t3_vld", 128'(ifa.o_ch_valid), 128'(8'h01));

    // 4: continuous, mask 03, three sequences
    tbl_a[0] = 12'h801; tbl_a[1] = 12'h3C3;
    e0 = en_cnt_a;
    @(negedge clk); ifa.i_ch_mask = 8'h03; ifa.i_cont = 1'b1;
    wait_en_a(e0 + 2, 400);
    repeat (5) @(negedge clk);
    chk("t4_gap", 128'(gap_a), 128'(2));
    ifa.i_cont = 1'b0;
    repeat (10) @(negedge clk);
    ifa.i_sn_adc = 1'b1; @(negedge clk); ifa.i_sn_adc = 1'b0;
    wait_en_a(e0 + 3, 300);
    repeat (300) @(negedge clk);
    chk("t4_en3", 128'(en_cnt_a - e0), 128'(3));
    chk("t4_busy", 128'(ifa.o_busy), 128'(0));
    chk("t4_vld", 128'(ifa.o_ch_valid), 128'(8'h03));
    chk("t4_lane0", 128'(ifa.o_adc_value[0 +: 12]), 128'(12'h801));
    chk("t4_lane1", 128'(ifa.o_adc_value[12 +: 12]), 128'(12'h3C3));

    // 5: reset 10 clk into the first frame
    tbl_a[0] = 12'hA5A; tbl_a[2] = 12'h123;
    trig_a(8'h05);
    repeat (10) @(negedge clk);
    chk("t5_inframe", 128'(ifa.spi_ss), 128'(0));
    rst_a = 1'b1;
    @(negedge clk);
    chk("t5_ss", 128'(ifa.spi_ss), 128'(1));
    chk("t5_sck", 128'(ifa.spi_sck), 128'(1));
    chk("t5_busy", 128'(ifa.o_busy), 128'(0));
    chk("t5_vld", 128'(ifa.o_ch_valid), 128'(0));
    rst_a = 1'b0;
    e0 = en_cnt_a;
    trig_a(8'h05);
    wait_en_a(e0 + 1, 300);
    repeat (3) @(negedge clk);
    ea = '0; ea[0 +: 12] = tbl_a[0]; ea[24 +: 12] = tbl_a[2];
    chk("t5_bus", 128'(ifa.o_adc_value), 128'(ea));
    chk("t5_vld2", 128'(ifa.o_ch_valid), 128'(8'h05));

    // 2: instance B, mask FF, SCK_DIV=3, 8-bit results
    addr_log_b.delete(); e0 = en_cnt_b; f0 = nfall_b;
    trig_b(8'hFF);
    wait_en_b(e0 + 1, 1200);
    repeat (5) @(negedge clk);
    chk("t2_frames", 128'(nfall_b - f0), 128'(9));
    chk("t2_cslow", 128'(lowlen_b), 128'(99));
    chk("t2_cshigh", 128'(hilen_b), 128'(3));
    chk("t2_sckper", 128'(per_b), 128'(6));
    chk("t2_nlog", 128'(addr_log_b.size()), 128'(9));
    if (addr_log_b.size() == 9) begin
      for (int k = 0; k < 9; k++) chk("t2_add", 128'(addr_log_b[k]), 128'(k % 8));
    end
    eb = '0;
    for (int k = 0; k < 8; k++) begin t = tbl_b[k]; eb[k*8 +: 8] = t[11:4]; end
    chk("t2_bus", 128'(ifb.o_adc_value), 128'(eb));
    chk("t2_vld", 128'(ifb.o_ch_valid), 128'(8'hFF));
    chk("t2_err", 128'(err_cnt_b), 128'(0));
    chk("t2_word", 128'(bad_b), 128'(0));

    // 6: channel 7 only, then an empty mask
    tbl_b[7] = 12'hC3E;
    addr_log_b.delete(); e0 = en_cnt_b;
    trig_b(8'h80);
    wait_en_b(e0 + 1, 400);
    repeat (5) @(negedge clk);
    chk("t6_nlog", 128'(addr_log_b.size()), 128'(2));
    if (addr_log_b.size() == 2) begin
      chk("t6_add0", 128'(addr_log_b[0]), 128'(7));
      chk("t6_add1", 128'(addr_log_b[1]), 128'(7));
    end
    eb[56 +: 8] = 8'hC3;
    chk("t6_bus", 128'(ifb.o_adc_value), 128'(eb));
    chk("t6_vld", 128'(ifb.o_ch_valid), 128'(8'h80));
    f0 = nfall_b; e0 = en_cnt_b;
    trig_b(8'h00);
    chk("t6_zero_busy", 128'(ifb.o_busy), 128'(0));
    repeat (50) @(negedge clk);
    chk("t6_zero_cs", 128'(nfall_b - f0), 128'(0));
    chk("t6_zero_en", 128'(en_cnt_b - e0), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
